// File: rtl/jtframe_dump_ctrl.sv
// Frame-based sequencer that opens and closes the simulation waveform-dump
// window, counting frames on falling edges of vertical sync.
module jtframe_dump_ctrl #(
  parameter int CW      = 32,
  parameter int WAIT_DL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          downloading,
  input  logic [CW-1:0] start_frame,
  input  logic [CW-1:0] dump_len,
  input  logic          stop_req,
  input  logic          rearm,
  output logic [CW-1:0] frame_cnt,
  output logic          dump_en,
  output logic          dump_start,
  output logic          dump_stop,
  output logic [1:0]    st
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_ARM  = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam bit     USE_DL = (WAIT_DL != 0);
  localparam state_t RST_ST = USE_DL ? S_WAIT : S_ARM;

  state_t        st_q, st_n;
  logic          vs_l, dl_l;
  logic          vs_fall, dl_fall, dl_rise;
  logic [CW-1:0] start_l, start_l_n;
  logic [CW-1:0] len_l, len_l_n;
  logic [CW-1:0] rem_q, rem_n;
  logic          en_n, start_n, stop_n;

  assign vs_fall = vs_l & ~vs;
  assign dl_fall = dl_l & ~downloading;
  assign dl_rise = ~dl_l & downloading;
  assign st      = st_q;

  always_comb begin
    st_n      = st_q;
    en_n      = dump_en;
    start_n   = 1'b0;
    stop_n    = 1'b0;
    rem_n     = rem_q;
    start_l_n = start_l;
    len_l_n   = len_l;
    if (USE_DL && dl_rise) begin
      // a new download invalidates any window in progress
      st_n   = S_WAIT;
      en_n   = 1'b0;
      stop_n = (st_q == S_DUMP);
    end else if (stop_req && st_q != S_DONE) begin
      st_n   = S_DONE;
      en_n   = 1'b0;
      stop_n = (st_q == S_DUMP);
    end else begin
      unique case (st_q)
        S_WAIT: begin
          if (dl_fall) begin
            st_n      = S_ARM;
            start_l_n = start_frame;
            len_l_n   = dump_len;
          end
        end
        S_ARM: begin
          if (vs_fall && frame_cnt >= start_l) begin
            st_n    = S_DUMP;
            en_n    = 1'b1;
            start_n = 1'b1;
            rem_n   = len_l;
          end
        end
        S_DUMP: begin
          // len_l == 0 keeps the window open indefinitely
          if (vs_fall && len_l != '0) begin
            if (rem_q == CW'(1)) begin
              st_n   = S_DONE;
              en_n   = 1'b0;
              stop_n = 1'b1;
            end else begin
              rem_n = rem_q - CW'(1);
            end
          end
        end
        S_DONE: begin
          if (rearm) begin
            st_n      = S_ARM;
            start_l_n = start_frame;
            len_l_n   = dump_len;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= RST_ST;
    end else begin
      st_q <= st_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_l       <= 1'b0;
      dl_l       <= 1'b0;
      frame_cnt  <= '0;
      dump_en    <= 1'b0;
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
      rem_q      <= '0;
      start_l    <= USE_DL ? '0 : start_frame;
      len_l      <= USE_DL ? '0 : dump_len;
    end else begin
      vs_l       <= vs;
      dl_l       <= downloading;
      dump_en    <= en_n;
      dump_start <= start_n;
      dump_stop  <= stop_n;
      rem_q      <= rem_n;
      start_l    <= start_l_n;
      len_l      <= len_l_n;
      if (vs_fall) begin
        frame_cnt <= frame_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Directed bench for jtframe_dump_ctrl: three instances share stimulus,
// each held in reset while another one runs its scenario.
module tb_jtframe_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic        vs = 1'b0, downloading = 1'b0;
  logic [31:0] start_frame = '0, dump_len = '0;
  logic        stop_req = 1'b0, rearm = 1'b0;

  logic [31:0] fc_a, fc_b;
  logic [3:0]  fc_c;
  logic        en_a, en_b, en_c;
  logic        sa, sb, sc, pa, pb, pc;
  logic [1:0]  st_a, st_b, st_c;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int inst;
    bit is_start;
    int fc;
  } ev_t;
  ev_t q[$];

  always #5 clk = ~clk;

  jtframe_dump_ctrl #(.CW(32), .WAIT_DL(0)) u_a (
    .clk(clk), .rst(rst_a), .vs(vs), .downloading(downloading),
    .start_frame(start_frame), .dump_len(dump_len),
    .stop_req(stop_req), .rearm(rearm), .frame_cnt(fc_a),
    .dump_en(en_a), .dump_start(sa), .dump_stop(pa), .st(st_a));

  jtframe_dump_ctrl #(.CW(32), .WAIT_DL(1)) u_b (
    .clk(clk), .rst(rst_b), .vs(vs), .downloading(downloading),
    .start_frame(start_frame), .dump_len(dump_len),
    .stop_req(stop_req), .rearm(rearm), .frame_cnt(fc_b),
    .dump_en(en_b), .dump_start(sb), .dump_stop(pb), .st(st_b));

  jtframe_dump_ctrl #(.CW(4), .WAIT_DL(0)) u_c (
    .clk(clk), .rst(rst_c), .vs(vs), .downloading(downloading),
    .start_frame(start_frame[3:0]), .dump_len(dump_len[3:0]),
    .stop_req(stop_req), .rearm(rearm), .frame_cnt(fc_c),
    .dump_en(en_c), .dump_start(sc), .dump_stop(pc), .st(st_c));

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push(int inst, bit s, int fc);
    ev_t e;
    e.inst = inst;
    e.is_start = s;
    e.fc = fc;
    q.push_back(e);
  endfunction

  task automatic see(int inst, bit s, int fc);
    ev_t e;
    if (q.size() == 0) begin
      chk("unexpected_pulse", inst * 2 + int'(s), -1);
    end else begin
      e = q.pop_front();
      chk("pulse_inst", inst, e.inst);
      chk("pulse_kind", s, e.is_start);
      chk("pulse_fc", fc, e.fc);
    end
  endtask

  always @(negedge clk) begin
    if (sa) see(0, 1'b1, int'(fc_a));
    if (pa) see(0, 1'b0, int'(fc_a));
    if (sb) see(1, 1'b1, int'(fc_b));
    if (pb) see(1, 1'b0, int'(fc_b));
    if (sc) see(2, 1'b1, int'(fc_c));
    if (pc) see(2, 1'b0, int'(fc_c));
  end

  // one frame; the falling edge of vs is sampled on the last posedge
  task automatic frame(bit with_stop);
    @(posedge clk); #1 vs = 1'b1;
    repeat (2) @(posedge clk);
    #1 vs = 1'b0;
    stop_req = with_stop;
    @(posedge clk); #1 stop_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_rearm();
    @(posedge clk); #1 rearm = 1'b1;
    @(posedge clk); #1 rearm = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 stop_req = 1'b1;
    @(posedge clk); #1 stop_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_dl(bit v);
    @(posedge clk); #1 downloading = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit all_high;

    // instance a: no download wait, start 3, length 2
    start_frame = 32'd3;
    dump_len    = 32'd2;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    chk("a_rst_fc", fc_a, 0);
    chk("a_rst_en", en_a, 0);
    chk("a_rst_st", st_a, 1);
    push(0, 1'b1, 4);
    push(0, 1'b0, 6);
    for (int k = 1; k <= 6; k++) begin
      frame(1'b0);
      chk("a_fc", fc_a, k);
      chk("a_en", en_a, (k == 4 || k == 5) ? 1 : 0);
    end
    chk("a_done", st_a, 3);

    // hold in DONE until frame 25, then re-arm with start 20 length 1
    for (int k = 7; k <= 25; k++) frame(1'b0);
    chk("a_hold_en", en_a, 0);
    chk("a_fc25", fc_a, 25);
    start_frame = 32'd20;
    dump_len    = 32'd1;
    pulse_rearm();
    chk("a_rearm_st", st_a, 1);
    push(0, 1'b1, 26);
    push(0, 1'b0, 27);
    frame(1'b0);
    chk("a_open_en", en_a, 1);
    chk("a_open_st", st_a, 2);
    frame(1'b0);
    chk("a_close_en", en_a, 0);
    chk("a_close_st", st_a, 3);

    // unlimited window closed by stop_req coinciding with vs_fall
    start_frame = 32'd0;
    dump_len    = 32'd0;
    pulse_rearm();
    push(0, 1'b1, 28);
    frame(1'b0);
    chk("a_unl_en", en_a, 1);
    push(0, 1'b0, 29);
    frame(1'b1);
    chk("a_stopvs_st", st_a, 3);
    chk("a_stopvs_pulse", pa, 1);
    chk("a_stopvs_fc", fc_a, 29);

    // stop_req while ARMED closes silently
    start_frame = 32'd100;
    pulse_rearm();
    chk("a_arm_st", st_a, 1);
    pulse_stop();
    chk("a_armstop_st", st_a, 3);
    chk("a_armstop_en", en_a, 0);

    // instance b: wait for download, start 0, unlimited
    #1 rst_a = 1'b1;
    downloading = 1'b1;
    start_frame = 32'd0;
    dump_len    = 32'd0;
    @(posedge clk); #1 rst_b = 1'b0;
    @(negedge clk);
    chk("b_rst_st", st_b, 0);
    chk("b_rst_fc", fc_b, 0);
    for (int k = 1; k <= 10; k++) frame(1'b0);
    chk("b_wait_st", st_b, 0);
    set_dl(1'b0);
    chk("b_dlfall_st", st_b, 1);
    chk("b_dlfall_fc", fc_b, 10);
    push(1, 1'b1, 11);
    frame(1'b0);
    chk("b_open_en", en_b, 1);
    all_high = 1'b1;
    for (int k = 0; k < 100; k++) begin
      frame(1'b0);
      if (en_b !== 1'b1) all_high = 1'b0;
    end
    chk("b_100_high", all_high, 1);
    chk("b_fc111", fc_b, 111);
    push(1, 1'b0, 111);
    set_dl(1'b1);
    chk("b_dlrise_st", st_b, 0);
    chk("b_dlrise_en", en_b, 0);
    frame(1'b0);
    frame(1'b0);
    set_dl(1'b0);
    chk("b_rearm_st", st_b, 1);
    push(1, 1'b1, 114);
    frame(1'b0);
    chk("b_reopen_en", en_b, 1);
    push(1, 1'b0, 114);
    pulse_stop();
    chk("b_stop_st", st_b, 3);

    // instance c: 4-bit counter wraps while dumping, then async reset
    #1 rst_b = 1'b1;
    start_frame = 32'd12;
    dump_len    = 32'd0;
    @(posedge clk); #1 rst_c = 1'b0;
    @(negedge clk);
    chk("c_rst_st", st_c, 1);
    push(2, 1'b1, 13);
    for (int k = 1; k <= 20; k++) begin
      frame(1'b0);
      if (k == 15) chk("c_fc15", fc_c, 15);
      if (k == 16) chk("c_wrap", fc_c, 0);
    end
    chk("c_fc20", fc_c, 4);
    chk("c_en20", en_c, 1);
    chk("c_st20", st_c, 2);
    @(posedge clk); #2 rst_c = 1'b1;
    #1;
    chk("c_async_en", en_c, 0);
    chk("c_async_fc", fc_c, 0);
    chk("c_async_st", st_c, 1);
    @(posedge clk); #1 rst_c = 1'b0;
    @(negedge clk);
    chk("c_post_st", st_c, 1);
    chk("c_post_en", en_c, 0);
    repeat (3) @(negedge clk);

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
